// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Serial program loader. Receives a byte stream (sync 8'hA5, 16-bit word
// count low byte first, 4*N little-endian data bytes, optional checksum),
// writes each assembled word into instruction memory, and holds the CPU in
// reset until the load completes.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   When defined, one XOR checksum byte is expected after the data and a
//   mismatch aborts the load.
//
// Parameters
//   BASE_ADDR : byte address of the first loaded word
//   MAX_WORDS : largest accepted word count
//
// Ports
//   clk       : single clock, rising edge
//   reset     : synchronous active-high reset
//   rx_data   : received byte
//   rx_valid  : rx_data valid for this cycle
//   mem_we    : one-cycle instruction-memory write strobe
//   mem_addr  : word-aligned byte address of the write
//   mem_wdata : word to write
//   cpu_hold  : holds the CPU in reset while high
//   done      : load completed successfully
//   error     : load aborted, sticky until reset
// ---------------------------------------------------------------------------
module prog_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      DATA   = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK  = 3'd4,
`endif
      DONE   = 3'd5,
      ERROR  = 3'd6
   } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
   // Running XOR over every data byte of the stream.
   function automatic logic [7:0] csum_update(input logic [7:0] acc,
                                              input logic [7:0] b);
      return acc ^ b;
   endfunction
`endif

   state_t      state_r;
   logic [15:0] count_r;      // word count N (low byte latched in LEN_LO)
   logic [15:0] word_idx_r;   // index of the word being assembled
   logic [1:0]  byte_idx_r;   // byte position inside the current word
   logic [23:0] partial_r;    // bytes 0..2 of the current word
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]  csum_r;
`endif

   logic [15:0] len_s;
   logic        oversize_s;
   logic        last_word_s;
   logic [31:0] word_addr_s;

   // Full count as it becomes known on the LEN_HI byte.
   assign len_s       = {rx_data, count_r[7:0]};
   assign oversize_s  = ({16'd0, len_s} > 32'(MAX_WORDS));
   assign last_word_s = ((word_idx_r + 16'd1) == count_r);
   // 32-bit add, wraps modulo 2^32 by construction.
   assign word_addr_s = BASE_ADDR + {14'd0, word_idx_r, 2'b00};

   // Loader FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         count_r    <= 16'd0;
         word_idx_r <= 16'd0;
         byte_idx_r <= 2'd0;
         partial_r  <= 24'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
         csum_r     <= 8'd0;
`endif
         mem_we     <= 1'b0;
         mem_addr   <= BASE_ADDR;
         mem_wdata  <= 32'd0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         // Strobe is a single-cycle pulse unless re-armed below.
         mem_we <= 1'b0;
         if (rx_valid) begin
            case (state_r)
               IDLE: begin
                  if (rx_data == SYNC_BYTE) begin
                     state_r <= LEN_LO;
                  end
               end
               LEN_LO: begin
                  count_r[7:0] <= rx_data;
                  state_r      <= LEN_HI;
               end
               LEN_HI: begin
                  count_r    <= len_s;
                  word_idx_r <= 16'd0;
                  byte_idx_r <= 2'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum_r     <= 8'd0;
`endif
                  if (len_s == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                     state_r  <= CHECK;
`else
                     state_r  <= DONE;
                     cpu_hold <= 1'b0;
                     done     <= 1'b1;
`endif
                  end else if (oversize_s) begin
                     state_r <= ERROR;
                     error   <= 1'b1;
                  end else begin
                     state_r <= DATA;
                  end
               end
               DATA: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                  csum_r <= csum_update(csum_r, rx_data);
`endif
                  byte_idx_r <= byte_idx_r + 2'd1;
                  case (byte_idx_r)
                     2'd0: partial_r[7:0]   <= rx_data;
                     2'd1: partial_r[15:8]  <= rx_data;
                     2'd2: partial_r[23:16] <= rx_data;
                     2'd3: begin
                        mem_wdata  <= {rx_data, partial_r};
                        mem_addr   <= word_addr_s;
                        mem_we     <= 1'b1;
                        partial_r  <= 24'd0;
                        word_idx_r <= word_idx_r + 16'd1;
                        if (last_word_s) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                           state_r  <= CHECK;
`else
                           state_r  <= DONE;
                           cpu_hold <= 1'b0;
                           done     <= 1'b1;
`endif
                        end
                     end
                     default: partial_r <= 24'd0;
                  endcase
               end
`ifdef PROG_LOADER_CHECKSUM_EN
               CHECK: begin
                  if (rx_data == csum_r) begin
                     state_r  <= DONE;
                     cpu_hold <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     state_r <= ERROR;
                     error   <= 1'b1;
                  end
               end
`endif
               DONE: begin
                  // A new sync byte starts a fresh load from word 0.
                  if (rx_data == SYNC_BYTE) begin
                     state_r    <= LEN_LO;
                     cpu_hold   <= 1'b1;
                     done       <= 1'b0;
                     word_idx_r <= 16'd0;
                     byte_idx_r <= 2'd0;
                     partial_r  <= 24'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                     csum_r     <= 8'd0;
`endif
                  end
               end
               ERROR: begin
                  // Locked until reset.
                  error    <= 1'b1;
                  cpu_hold <= 1'b1;
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h00000000, byte address of the first loaded word.
REQ-002 Parameter MAX_WORDS, default 1024, largest accepted word count.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 rx_data  input  8  received byte.
REQ-006 rx_valid  input  1  rx_data valid for exactly this cycle; may be high on consecutive cycles.
REQ-007 mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-008 mem_addr  output  32  word-aligned byte address of the write.
REQ-009 mem_wdata  output  32  word to write.
REQ-010 cpu_hold  output  1  keeps the CPU in reset while high.
REQ-011 done  output  1  load completed successfully.
REQ-012 error  output  1  load aborted; sticky until reset.

Function
REQ-013 The stream format SHALL be: sync byte 8'hA5; count N (2 bytes, low byte first); 4*N data bytes, each word little-endian; optional checksum byte (REQ-031).
REQ-014 The states SHALL be IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE and ERROR.
REQ-015 IDLE: ignore bytes other than 8'hA5; on 8'hA5 go to LEN_LO.
REQ-016 LEN_LO: latch the low count byte, go to LEN_HI.
REQ-017 LEN_HI: latch the high byte. N=0 -> CHECK if enabled, else DONE. N>MAX_WORDS -> ERROR. Otherwise -> DATA.
REQ-018 DATA: byte k of each word fills bits [8k+7:8k], k=0..3.
REQ-019 On the edge that accepts byte 3, the module SHALL register mem_wdata and mem_addr and assert mem_we for exactly the following cycle.
REQ-020 The address of word j SHALL be BASE_ADDR + 4*j; a 32-bit add that wraps modulo 2^32.
REQ-021 After word N-1 the state SHALL go to CHECK if enabled, else DONE.
REQ-022 Back-to-back rx_valid SHALL be accepted with no byte dropped; sustained rate is one word per 4 cycles.
REQ-023 Cycles with rx_valid low SHALL not change any state, partial word or counter.
REQ-024 DONE: cpu_hold=0 and done=1. An 8'hA5 in DONE SHALL restart at LEN_LO, with cpu_hold=1, done=0 and the word index cleared.
REQ-025 DONE: all bytes other than 8'hA5 SHALL be ignored.
REQ-026 ERROR: error=1 and cpu_hold=1; all bytes ignored until reset.
REQ-027 mem_we SHALL never be asserted outside the cycle defined in REQ-019.

Reset
REQ-028 When reset is high at a clock edge, the following SHALL apply on that edge: state=IDLE; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; cpu_hold=1; done=0; error=0; partial word, byte index, word index, count and checksum all cleared.
REQ-029 Reset mid-load SHALL discard the partial word and SHALL not generate a write.
REQ-030 Reset SHALL take priority over a simultaneous rx_valid.

Configuration
REQ-031 With PROG_LOADER_CHECKSUM_EN defined:
- The CHECK state exists.
- One byte is expected after the data: the XOR of all 4*N data bytes, or 8'h00 when N=0.
- Match -> DONE; mismatch -> ERROR.
- Writes already issued are not retracted.
REQ-032 Without PROG_LOADER_CHECKSUM_EN, CHECK is absent and the last data byte leads directly to DONE.

Verification
REQ-033 Reset, then A5 02 00 13 05 10 00 93 02 F0 FF back-to-back -> mem_we at 0x00000000/0x00100513, then at 0x00000004/0xFFF00293; done=1, cpu_hold=0.
REQ-034 Bytes 00 FF then A5 01 00 EF BE AD DE, with 2 idle cycles between bytes -> one write at 0x00000000/0xDEADBEEF; leading bytes ignored.
REQ-035 A5 01 04 with MAX_WORDS=1024 (N=1025) -> error=1, cpu_hold=1, no mem_we; later A5 bytes ignored until reset.
REQ-036 After two of four data bytes, reset pulsed -> no mem_we; state IDLE, cpu_hold=1; a following full load writes at BASE_ADDR.
REQ-037 With the macro: A5 01 00 11 22 33 44 44 -> write 0x44332211 at 0x00000000, then done=1. Same stream ending 45 -> error=1.
REQ-038 After done, send A5 01 00 01 00 00 00 -> cpu_hold rises, done falls, write at 0x00000000/0x00000001, then done=1 again.
